// File: rtl/i2c_slave_regs.sv
// I2C slave exposing a 2^NREG_W x 8-bit register file. It reports every bus
// write on a strobe port and gives the fabric a combinational read port.
module i2c_slave_regs #(
    parameter logic [6:0] SLV_ADR = 7'h2A,
    parameter int         NREG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCL,
    input  logic              SDA_in,
    output logic              SDA_SLAVE,
    output logic              busy,
    output logic              ce_wr,
    output logic [NREG_W-1:0] adr_wr,
    output logic [7:0]        dat_wr,
    input  logic [NREG_W-1:0] rd_adr,
    output logic [7:0]        rd_dat
);
    localparam int NREG = 1 << NREG_W;

    typedef enum logic [2:0] {IDLE, ADR, REG, WDAT, RDAT, WAIT_P} state_t;

    logic [2:0]        r_sclSync, r_sdaSync;
    logic              r_sclRise, r_sclFall, r_start, r_stop, r_sdaBit;
    logic              w_sclRise, w_sclFall, w_start, w_stop;

    state_t            r_state, w_stateNext;
    logic [3:0]        r_cbBit, w_cbBitNext;
    logic              r_skip, w_skipNext;
    logic [7:0]        r_shift, w_shiftNext;
    logic [NREG_W-1:0] r_ptr, w_ptrNext, w_ptrInc;
    logic              r_rw, w_rwNext;
    logic              r_busy, w_busyNext;
    logic              r_sda, w_sdaNext;
    logic              r_ceWr, w_ceWrNext;
    logic [NREG_W-1:0] r_adrWr, w_adrWrNext;
    logic [7:0]        r_datWr, w_datWrNext;
    logic [7:0]        r_regs [NREG];
    logic [7:0]        w_rdCur, w_rdNext;

    // Bus events are registered once more so every output moves 4 clk after a pin edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclSync <= '1;
            r_sdaSync <= '1;
            r_sclRise <= 1'b0;
            r_sclFall <= 1'b0;
            r_start   <= 1'b0;
            r_stop    <= 1'b0;
            r_sdaBit  <= 1'b1;
        end else begin
            r_sclSync <= {r_sclSync[1:0], SCL};
            r_sdaSync <= {r_sdaSync[1:0], SDA_in};
            r_sclRise <= w_sclRise;
            r_sclFall <= w_sclFall;
            r_start   <= w_start;
            r_stop    <= w_stop;
            r_sdaBit  <= r_sdaSync[1];
        end
    end

    assign w_sclRise = r_sclSync[1] & ~r_sclSync[2];
    assign w_sclFall = ~r_sclSync[1] & r_sclSync[2];
    assign w_start   = r_sclSync[1] & r_sclSync[2] & r_sdaSync[2] & ~r_sdaSync[1];
    assign w_stop    = r_sclSync[1] & r_sclSync[2] & ~r_sdaSync[2] & r_sdaSync[1];

    assign w_ptrInc = r_ptr + NREG_W'(1);
    assign w_rdCur  = r_regs[r_ptr];
    assign w_rdNext = r_regs[w_ptrInc];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cbBit <= '0;
            r_skip  <= 1'b0;
            r_shift <= '0;
            r_ptr   <= '0;
            r_rw    <= 1'b0;
            r_busy  <= 1'b0;
            r_sda   <= 1'b1;
            r_ceWr  <= 1'b0;
            r_adrWr <= '0;
            r_datWr <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cbBit <= w_cbBitNext;
            r_skip  <= w_skipNext;
            r_shift <= w_shiftNext;
            r_ptr   <= w_ptrNext;
            r_rw    <= w_rwNext;
            r_busy  <= w_busyNext;
            r_sda   <= w_sdaNext;
            r_ceWr  <= w_ceWrNext;
            r_adrWr <= w_adrWrNext;
            r_datWr <= w_datWrNext;
        end
    end

    // cb_bit counts SCL falls; the fall that merely follows a START is skipped.
    always_comb begin
        w_stateNext = r_state;
        w_cbBitNext = r_cbBit;
        w_skipNext  = r_skip;
        w_shiftNext = r_shift;
        w_ptrNext   = r_ptr;
        w_rwNext    = r_rw;
        w_busyNext  = r_busy;
        w_sdaNext   = r_sda;
        w_ceWrNext  = 1'b0;
        w_adrWrNext = r_adrWr;
        w_datWrNext = r_datWr;
        if (r_stop) begin
            w_stateNext = IDLE;
            w_busyNext  = 1'b0;
            w_sdaNext   = 1'b1;
        end else if (r_start) begin
            w_stateNext = ADR;
            w_cbBitNext = '0;
            w_skipNext  = 1'b1;
            w_sdaNext   = 1'b1;
        end else if (r_sclRise) begin
            if ((r_state == ADR || r_state == REG || r_state == WDAT) && r_cbBit < 4'd8) begin
                w_shiftNext = {r_shift[6:0], r_sdaBit};
            end else if (r_state == RDAT && r_cbBit == 4'd8 && r_sdaBit) begin
                w_stateNext = WAIT_P;
                w_busyNext  = 1'b0;
            end
        end else if (r_sclFall) begin
            if (r_skip) begin
                w_skipNext = 1'b0;
            end else begin
                case (r_state)
                    ADR: begin
                        if (r_cbBit == 4'd7) begin
                            if (r_shift[7:1] == SLV_ADR) begin
                                w_sdaNext   = 1'b0;
                                w_rwNext    = r_shift[0];
                                w_busyNext  = 1'b1;
                                w_cbBitNext = 4'd8;
                            end else begin
                                w_stateNext = WAIT_P;
                            end
                        end else if (r_cbBit == 4'd8) begin
                            w_sdaNext   = 1'b1;
                            w_stateNext = REG;
                            w_cbBitNext = '0;
                        end else begin
                            w_cbBitNext = r_cbBit + 4'd1;
                        end
                    end
                    REG: begin
                        if (r_cbBit == 4'd7) begin
                            w_ptrNext   = r_shift[NREG_W-1:0];
                            w_sdaNext   = 1'b0;
                            w_cbBitNext = 4'd8;
                        end else if (r_cbBit == 4'd8) begin
                            w_cbBitNext = '0;
                            if (r_rw) begin
                                w_stateNext = RDAT;
                                w_shiftNext = w_rdCur;
                                w_sdaNext   = w_rdCur[7];
                            end else begin
                                w_stateNext = WDAT;
                                w_sdaNext   = 1'b1;
                            end
                        end else begin
                            w_cbBitNext = r_cbBit + 4'd1;
                        end
                    end
                    WDAT: begin
                        if (r_cbBit == 4'd7) begin
                            w_ceWrNext  = 1'b1;
                            w_adrWrNext = r_ptr;
                            w_datWrNext = r_shift;
                            w_sdaNext   = 1'b0;
                            w_ptrNext   = w_ptrInc;
                            w_cbBitNext = 4'd8;
                        end else if (r_cbBit == 4'd8) begin
                            w_sdaNext   = 1'b1;
                            w_cbBitNext = '0;
                        end else begin
                            w_cbBitNext = r_cbBit + 4'd1;
                        end
                    end
                    RDAT: begin
                        if (r_cbBit < 4'd7) begin
                            w_shiftNext = {r_shift[6:0], 1'b0};
                            w_sdaNext   = r_shift[6];
                            w_cbBitNext = r_cbBit + 4'd1;
                        end else if (r_cbBit == 4'd7) begin
                            w_sdaNext   = 1'b1;
                            w_cbBitNext = 4'd8;
                        end else begin
                            w_ptrNext   = w_ptrInc;
                            w_shiftNext = w_rdNext;
                            w_sdaNext   = w_rdNext[7];
                            w_cbBitNext = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // The register commits at the end of the ce_wr cycle, so a same-clk fabric read sees the old byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (r_ceWr) begin
            r_regs[r_adrWr] <= r_datWr;
        end
    end

    assign rd_dat    = r_regs[rd_adr];
    assign SDA_SLAVE = r_sda;
    assign busy      = r_busy;
    assign ce_wr     = r_ceWr;
    assign adr_wr    = r_adrWr;
    assign dat_wr    = r_datWr;
endmodule
